// File: rtl/uart_loader.sv
// UART boot loader: deserializes a length-prefixed, XOR-checksummed image from
// uart_in, writes it to memory word by word and releases the core on success.
module uart_loader #(
  parameter int unsigned WAIT_DIV  = 104,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_in,
  output logic [31:0] addr,
  output logic        wen,
  output logic [31:0] wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W   = $clog2(WAIT_DIV + 1);
  localparam int unsigned HALF_M1 = (WAIT_DIV / 2 > 0) ? (WAIT_DIV / 2 - 1) : 0;
  localparam int unsigned FULL_M1 = (WAIT_DIV > 0) ? (WAIT_DIV - 1) : 0;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LD_LEN   = 3'd0;
  localparam logic [2:0] LD_DATA  = 3'd1;
  localparam logic [2:0] LD_CSUM  = 3'd2;
  localparam logic [2:0] LD_DONE  = 3'd3;
  localparam logic [2:0] LD_ERROR = 3'd4;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value
  logic [2:0]       sync_q;
  logic [1:0]       rx_state, rx_state_d;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]       rx_bit, rx_bit_d;
  logic [7:0]       rx_shift, rx_shift_d;
  logic             byte_valid, byte_valid_d;
  logic             frame_err, frame_err_d;
  logic             rx_in, rx_prev;

  assign rx_in   = sync_q[1];
  assign rx_prev = sync_q[2];

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], uart_in};
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_bit     <= rx_bit_d;
      rx_shift   <= rx_shift_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  // RX next state: mid-bit sampling timed from the start-bit edge
  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt + CNT_W'(1);
    rx_bit_d     = rx_bit;
    rx_shift_d   = rx_shift;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_in) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNT_W'(HALF_M1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_in ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_W'(FULL_M1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in, rx_shift[7:1]};
          rx_bit_d   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (rx_cnt == CNT_W'(FULL_M1)) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_in) byte_valid_d = 1'b1;
          else       frame_err_d  = 1'b1;
        end
      end
    endcase
  end

  logic [2:0]  ld_state, ld_state_d;
  logic [1:0]  byte_cnt, byte_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [31:0] word_idx, word_idx_d;
  logic [7:0]  csum, csum_d;
  logic [31:0] addr_d, wdata_d;
  logic        wen_d, core_rst_n_d, busy_d, done_d, err_d;
  logic [31:0] new_len, new_word;

  assign new_len  = {rx_shift, len_q[31:8]};
  assign new_word = {rx_shift, word_q[31:8]};

  // loader state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state   <= LD_LEN;
      byte_cnt   <= '0;
      len_q      <= '0;
      word_q     <= '0;
      word_idx   <= '0;
      csum       <= '0;
      addr       <= '0;
      wdata      <= '0;
      wen        <= 1'b0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      ld_state   <= ld_state_d;
      byte_cnt   <= byte_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      word_idx   <= word_idx_d;
      csum       <= csum_d;
      addr       <= addr_d;
      wdata      <= wdata_d;
      wen        <= wen_d;
      core_rst_n <= core_rst_n_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // loader next state; every accepted byte before the checksum feeds the XOR
  always_comb begin
    ld_state_d   = ld_state;
    byte_cnt_d   = byte_cnt;
    len_d        = len_q;
    word_d       = word_q;
    word_idx_d   = word_idx;
    csum_d       = csum;
    addr_d       = addr;
    wdata_d      = wdata;
    wen_d        = 1'b0;
    core_rst_n_d = core_rst_n;
    busy_d       = busy;
    done_d       = done;
    err_d        = err;
    case (ld_state)
      LD_LEN, LD_DATA, LD_CSUM: begin
        if (frame_err) begin
          ld_state_d = LD_ERROR;
          err_d      = 1'b1;
          busy_d     = 1'b0;
        end else if (byte_valid) begin
          busy_d = 1'b1;
          if (ld_state == LD_CSUM) begin
            busy_d = 1'b0;
            if (rx_shift == csum) begin
              ld_state_d   = LD_DONE;
              done_d       = 1'b1;
              core_rst_n_d = 1'b1;
            end else begin
              ld_state_d = LD_ERROR;
              err_d      = 1'b1;
            end
          end else begin
            csum_d     = csum ^ rx_shift;
            byte_cnt_d = byte_cnt + 2'd1;
            if (ld_state == LD_LEN) begin
              len_d = new_len;
              if (byte_cnt == 2'd3) begin
                if (new_len > 32'(MAX_WORDS)) begin
                  ld_state_d = LD_ERROR;
                  err_d      = 1'b1;
                  busy_d     = 1'b0;
                end else if (new_len == 32'd0) begin
                  ld_state_d = LD_CSUM;
                end else begin
                  ld_state_d = LD_DATA;
                end
              end
            end else begin
              word_d = new_word;
              if (byte_cnt == 2'd3) begin
                wen_d      = 1'b1;
                wdata_d    = new_word;
                addr_d     = BASE_ADDR + {word_idx[29:0], 2'b00};
                word_idx_d = word_idx + 32'd1;
                if (word_idx == len_q - 32'd1) ld_state_d = LD_CSUM;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial images driven bit by bit, writes
// logged from the bus and compared against hand-computed values.
module tb_uart_loader;

  localparam int unsigned W = 4;

  logic        clk;
  logic        rst_n;
  logic        uart_in;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned errors;
  int unsigned checks;
  int unsigned wen_total;
  int unsigned base;
  logic [31:0] wr_addr_log [0:15];
  logic [31:0] wr_data_log [0:15];

  uart_loader #(
    .WAIT_DIV (W),
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_in   (uart_in),
    .addr      (addr),
    .wen       (wen),
    .wdata     (wdata),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // log every cycle wen is high; a stretched pulse shows up as an extra write
  always @(negedge clk) begin
    if (wen) begin
      wr_addr_log[wen_total[3:0]] <= addr;
      wr_data_log[wen_total[3:0]] <= wdata;
      wen_total <= wen_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_in = 1'b0;
    repeat (W) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (W) @(negedge clk);
    end
    uart_in = stop_bit;
    repeat (W) @(negedge clk);
    uart_in = 1'b1;
    repeat (3 * W) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    uart_in = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  addr, 32'h0);
    check({tag, "_wen"},   32'(wen), 32'h0);
    check({tag, "_wdata"}, wdata, 32'h0);
    check({tag, "_crst"},  32'(core_rst_n), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
    check({tag, "_err"},   32'(err), 32'h0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    wen_total = 0;
    rst_n     = 1'b0;
    uart_in   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // one-cycle low glitch on idle line
    uart_in = 1'b0;
    @(negedge clk);
    uart_in = 1'b1;
    repeat (6 * W) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_err", 32'(err), 32'h0);
    check("glitch_wen", 32'(wen_total), 32'd0);

    // two-word image, good checksum 0x33
    base = wen_total;
    send(8'h02);
    check("len0_busy", 32'(busy), 32'h1);
    send(8'h00); send(8'h00); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    check("w0_count", 32'(wen_total - base), 32'd1);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    check("w1_count", 32'(wen_total - base), 32'd2);
    check("w0_addr", wr_addr_log[base[3:0]], 32'h0);
    check("w0_data", wr_data_log[base[3:0]], 32'h0000_0013);
    check("w1_addr", wr_addr_log[4'(base + 1)], 32'h4);
    check("w1_data", wr_data_log[4'(base + 1)], 32'hDEAD_BEEF);
    check("held_addr", addr, 32'h4);
    check("held_data", wdata, 32'hDEAD_BEEF);
    check("pre_csum_done", 32'(done), 32'h0);
    send(8'h33);
    check("ok_done", 32'(done), 32'h1);
    check("ok_crst", 32'(core_rst_n), 32'h1);
    check("ok_err", 32'(err), 32'h0);
    check("ok_busy", 32'(busy), 32'h0);
    send(8'h55);
    check("ok_ignore_done", 32'(done), 32'h1);
    check("ok_ignore_wen", 32'(wen_total - base), 32'd2);

    // same image, bad checksum 0x34
    do_reset();
    check_reset_outputs("rst2");
    base = wen_total;
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h34);
    check("bad_count", 32'(wen_total - base), 32'd2);
    check("bad_err", 32'(err), 32'h1);
    check("bad_done", 32'(done), 32'h0);
    check("bad_crst", 32'(core_rst_n), 32'h0);
    check("bad_busy", 32'(busy), 32'h0);

    // zero-length image
    do_reset();
    base = wen_total;
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    check("zero_done_early", 32'(done), 32'h0);
    send(8'h00);
    check("zero_count", 32'(wen_total - base), 32'd0);
    check("zero_done", 32'(done), 32'h1);
    check("zero_crst", 32'(core_rst_n), 32'h1);
    check("zero_err", 32'(err), 32'h0);

    // length above MAX_WORDS
    do_reset();
    base = wen_total;
    send(8'h05); send(8'h00); send(8'h00); send(8'h00);
    check("max_err", 32'(err), 32'h1);
    check("max_busy", 32'(busy), 32'h0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("max_count", 32'(wen_total - base), 32'd0);
    check("max_done", 32'(done), 32'h0);

    // framing error: stop bit low
    do_reset();
    send_byte(8'hA5, 1'b0);
    check("frame_err", 32'(err), 32'h1);
    check("frame_done", 32'(done), 32'h0);
    check("frame_crst", 32'(core_rst_n), 32'h0);

    // reset mid-load, then a fresh one-word image
    do_reset();
    base = wen_total;
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    check("mid_count", 32'(wen_total - base), 32'd1);
    check("mid_data", wr_data_log[base[3:0]], 32'h1234_5678);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    base = wen_total;
    send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h01);
    check("re_count", 32'(wen_total - base), 32'd1);
    check("re_addr", wr_addr_log[base[3:0]], 32'h0);
    check("re_data", wr_data_log[base[3:0]], 32'hDDCC_BBAA);
    check("re_done", 32'(done), 32'h1);
    check("re_crst", 32'(core_rst_n), 32'h1);
    check("re_err", 32'(err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
Boot loader that receives a program image from a host over the UART RX line and writes it into memory as a bus write initiator, using the same addr/wen/wdata port the core uses for data stores. The core is held in reset through a dedicated reset output until the image has been written and its checksum verified. The block has its own RX deserializer and byte-level framing FSM; it is instantiated next to the core and multiplexed onto the memory data port while busy.

Parameters:
WAIT_DIV, 104, clk cycles per UART bit (12 MHz / 115.2 kbps)
BASE_ADDR, 32'h0000_0000, byte address of the first image word
MAX_WORDS, 4096, largest accepted image length in words

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
uart_in  input  1  serial RX line, idle high, 8N1, LSB first
addr  output  32  memory write byte address
wen  output  1  memory write enable, one-cycle pulse per word
wdata  output  32  memory write data
core_rst_n  output  1  reset for core; 0 until load succeeds
busy  output  1  load in progress
done  output  1  image loaded and checksum good (sticky)
err  output  1  load failed (sticky)

Behaviour:
- Reset values: addr=0, wen=0, wdata=0, core_rst_n=0, busy=0, done=0, err=0. All internal state is cleared. A reset mid-load discards the partial image, and the FSM restarts waiting for a length.
- RX path:
  - 2-FF synchronizer on uart_in.
  - RX states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized 1->0 transition enters START.
  - START: wait WAIT_DIV/2 cycles, then sample. A 1 is a glitch and returns to IDLE with no error. A 0 enters DATA.
  - DATA: 8 samples, one every WAIT_DIV cycles, LSB first.
  - STOP: sample after WAIT_DIV cycles. A 1 produces a one-cycle byte_valid with the byte. A 0 is a framing error and sets err.
- Loader FSM states: LEN, DATA, CSUM, DONE, ERROR.
- LEN: collects 4 bytes, little-endian, into N. busy rises on byte_valid of the first length byte.
  - After the 4th byte: if N > MAX_WORDS, go to ERROR.
  - If N == 0, go to CSUM.
  - Otherwise go to DATA.
- DATA: collects 4 bytes per word, little-endian.
  - In the cycle after the 4th byte_valid: wen=1 for exactly one cycle, wdata=word, addr=BASE_ADDR+4*i, where i is the 0-based word index.
  - addr and wdata hold their value until the next write.
  - After word N-1, go to CSUM.
- Checksum: an 8-bit running XOR of every received byte, covering the length bytes and the data bytes.
- CSUM: receives 1 byte.
  - Equal to the running XOR: go to DONE.
  - Otherwise: go to ERROR.
- DONE: done=1, busy=0, core_rst_n=1 from the cycle after the checksum byte_valid. All further RX bytes are ignored.
- ERROR: err=1, busy=0, core_rst_n stays 0, no further wen. Only rst_n exits ERROR.
- Framing error in any loader state goes to ERROR.
- done and err are never both 1.
- The word index counter is 32-bit. It cannot wrap, because N is bounded by MAX_WORDS.
- RX continues deserializing while wen pulses; the 1-cycle write never stalls reception. Bytes are at least 10*WAIT_DIV cycles apart.

Test Plan:
- WAIT_DIV=4. Send length 02 00 00 00, words 13 00 00 00 and EF BE AD DE, then csum 0x33.
  -> wen pulses at addr 0x0 with wdata 0x00000013, then at 0x4 with 0xDEADBEEF. Then done=1, core_rst_n=1, err=0, busy=0.
- Same stream with csum 0x34.
  -> both writes occur, then err=1, done=0, core_rst_n stays 0.
- Length 00 00 00 00, then csum 0x00.
  -> no wen pulse, done=1, core_rst_n=1.
- MAX_WORDS=4, length 05 00 00 00.
  -> err=1 right after the 4th length byte, no wen even if data bytes follow.
- Send a byte whose stop bit is driven 0.
  -> err=1.
  - Separately, a low pulse of 1 cycle on an idle line is ignored: no byte is received, busy stays 0.
- Assert rst_n low after the first word is written, release it, then send a full valid 1-word image.
  -> all outputs return to reset values during reset. The new image writes to BASE_ADDR, and done=1.
